// File: rtl/pwm_tim_mc_if.sv
// Bus bundle for pwm_tim_mc: register-file configuration in, PWM/status out.
// Optional dead-time insertion in the timer is enabled with PWM_DEADTIME_EN.
interface pwm_tim_mc_if #(
    parameter int WIDTH     = 16,
    parameter int NUM_CH    = 4,
    parameter int PSC_WIDTH = 16,
    parameter int DT_WIDTH  = 8
) ();
    // No valid/ready pair: every control input is level-sampled on each clk,
    // and every output is a registered level or a 1-clk pulse (update_evt).
    logic                    enable;
    logic [PSC_WIDTH-1:0]    prescaler;
    logic [1:0]              counter_mode;
    logic [WIDTH-1:0]        counter_period;
    logic [NUM_CH*WIDTH-1:0] pulse;
    logic                    auto_reload_preload;
    logic [DT_WIDTH-1:0]     dead_time;
    logic [NUM_CH-1:0]       out_p;
    logic [NUM_CH-1:0]       out_n;
    logic                    update_evt;
    logic [WIDTH-1:0]        cnt_o;
    logic                    dir_o;

    modport master (
        output enable, prescaler, counter_mode, counter_period, pulse,
               auto_reload_preload, dead_time,
        input  out_p, out_n, update_evt, cnt_o, dir_o
    );

    modport slave (
        input  enable, prescaler, counter_mode, counter_period, pulse,
               auto_reload_preload, dead_time,
        output out_p, out_n, update_evt, cnt_o, dir_o
    );
endinterface

// File: rtl/pwm_tim_mc.sv
// Multi-channel PWM timer: shared prescaled up/down/center/one-pulse counter, NUM_CH
// compare channels with complementary outputs. Dead-time insertion under PWM_DEADTIME_EN.
module pwm_tim_mc #(
    parameter int WIDTH     = 16,
    parameter int NUM_CH    = 4,
    parameter int PSC_WIDTH = 16,
    parameter int DT_WIDTH  = 8
) (
    input  logic          clk,
    input  logic          rst,
    pwm_tim_mc_if.slave   bus
);
    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_CENTER = 2'b10,
        MODE_OPM    = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0]     ONE_W  = WIDTH'(1);
    localparam logic [PSC_WIDTH-1:0] ONE_P  = PSC_WIDTH'(1);

    mode_e                   mode;
    logic                    tick;
    logic                    load_sh;
    logic [PSC_WIDTH-1:0]    psc_cnt_q, psc_cnt_d;
    logic [WIDTH-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]        arr_sh_q, arr_sh_d;
    logic [NUM_CH*WIDTH-1:0] ccr_sh_q, ccr_sh_d;
    logic                    dir_q, dir_d;
    logic                    uev_q, uev_d;
    logic                    armed_q, armed_d;
    logic [NUM_CH-1:0]       ref_w;
    logic [NUM_CH-1:0]       out_p_q, out_p_d, out_n_q, out_n_d;

    assign mode = mode_e'(bus.counter_mode);

    always_comb begin
        psc_cnt_d = psc_cnt_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        uev_d     = 1'b0;
        armed_d   = armed_q;
        tick      = bus.enable && (psc_cnt_q == bus.prescaler);
        // Dropping enable is what re-arms one-pulse mode.
        if (!bus.enable) armed_d = 1'b1;
        else             psc_cnt_d = tick ? '0 : psc_cnt_q + ONE_P;
        if (tick) begin
            case (mode)
                MODE_UP: begin
                    dir_d = 1'b0;
                    if (cnt_q >= arr_sh_q) begin cnt_d = '0; uev_d = 1'b1; end
                    else cnt_d = cnt_q + ONE_W;
                end
                MODE_DOWN: begin
                    dir_d = 1'b1;
                    if ((cnt_q == '0) || (cnt_q > arr_sh_q)) begin cnt_d = arr_sh_q; uev_d = 1'b1; end
                    else cnt_d = cnt_q - ONE_W;
                end
                MODE_CENTER: begin
                    if (arr_sh_q == '0) begin
                        cnt_d = '0; dir_d = 1'b0; uev_d = 1'b1;
                    end else if (!dir_q && (cnt_q < arr_sh_q)) begin
                        cnt_d = cnt_q + ONE_W;
                        dir_d = (cnt_d == arr_sh_q);
                    end else if (cnt_q > arr_sh_q) begin
                        cnt_d = arr_sh_q; dir_d = 1'b1;
                    end else if (cnt_q == '0) begin
                        // Only reachable when switching in from down mode at zero.
                        cnt_d = ONE_W; dir_d = (arr_sh_q == ONE_W);
                    end else begin
                        cnt_d = cnt_q - ONE_W;
                        dir_d = (cnt_q != ONE_W);
                        uev_d = (cnt_q == ONE_W);
                    end
                end
                MODE_OPM: begin
                    dir_d = 1'b0;
                    if (!armed_q) cnt_d = '0;
                    else if (cnt_q >= arr_sh_q) begin cnt_d = '0; uev_d = 1'b1; armed_d = 1'b0; end
                    else cnt_d = cnt_q + ONE_W;
                end
                default: ;
            endcase
        end
        // Reload uses the old shadow; a shadow loaded here is seen from the next tick.
        load_sh  = !bus.auto_reload_preload || !bus.enable || uev_d;
        arr_sh_d = load_sh ? bus.counter_period : arr_sh_q;
        ccr_sh_d = load_sh ? bus.pulse : ccr_sh_q;
    end

    always_comb begin
        ref_w = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ref_w[i] = (ccr_sh_q[i*WIDTH +: WIDTH] != '0) &&
                       ((ccr_sh_q[i*WIDTH +: WIDTH] > arr_sh_q) || (cnt_q < ccr_sh_q[i*WIDTH +: WIDTH]));
        end
    end

`ifdef PWM_DEADTIME_EN
    localparam logic [DT_WIDTH-1:0] DT_ONE = DT_WIDTH'(1);
    logic [NUM_CH-1:0]   ref_q, ref_d;
    logic [DT_WIDTH-1:0] dt_cnt_q [NUM_CH];
    logic [DT_WIDTH-1:0] dt_cnt_d [NUM_CH];

    always_comb begin
        out_p_d  = out_p_q;
        out_n_d  = out_n_q;
        ref_d    = ref_q;
        dt_cnt_d = dt_cnt_q;
        if (bus.enable) begin
            ref_d = ref_w;
            for (int i = 0; i < NUM_CH; i++) begin
                // Any ref edge blanks both sides and (re)starts the dead-time count.
                if ((ref_w[i] != ref_q[i]) && (bus.dead_time != '0)) begin
                    out_p_d[i]  = 1'b0;
                    out_n_d[i]  = 1'b0;
                    dt_cnt_d[i] = bus.dead_time;
                end else if (dt_cnt_q[i] > DT_ONE) begin
                    dt_cnt_d[i] = dt_cnt_q[i] - DT_ONE;
                end else begin
                    dt_cnt_d[i] = '0;
                    out_p_d[i]  = ref_w[i];
                    out_n_d[i]  = ~ref_w[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_q <= '0;
            for (int i = 0; i < NUM_CH; i++) dt_cnt_q[i] <= '0;
        end else begin
            ref_q    <= ref_d;
            dt_cnt_q <= dt_cnt_d;
        end
    end
`else
    logic unused_dead_time;
    assign unused_dead_time = ^bus.dead_time;

    always_comb begin
        out_p_d = bus.enable ? ref_w  : out_p_q;
        out_n_d = bus.enable ? ~ref_w : out_n_q;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            psc_cnt_q <= '0;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            uev_q     <= 1'b0;
            armed_q   <= 1'b1;
            arr_sh_q  <= '0;
            ccr_sh_q  <= '0;
            out_p_q   <= '0;
            out_n_q   <= '0;
        end else begin
            psc_cnt_q <= psc_cnt_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            uev_q     <= uev_d;
            armed_q   <= armed_d;
            arr_sh_q  <= arr_sh_d;
            ccr_sh_q  <= ccr_sh_d;
            out_p_q   <= out_p_d;
            out_n_q   <= out_n_d;
        end
    end

    assign bus.out_p      = out_p_q;
    assign bus.out_n      = out_n_q;
    assign bus.update_evt = uev_q;
    assign bus.cnt_o      = cnt_q;
    assign bus.dir_o      = dir_q;
endmodule

// File: tb/tb_pwm_tim_mc.sv
// Directed bench for pwm_tim_mc: counter modes, shadowing, compare boundaries,
// one-pulse re-arm, async reset and (with PWM_DEADTIME_EN) dead-time insertion.
module tb_pwm_tim_mc;
    logic clk;
    logic rst;
    int   cyc;
    int   tests;
    int   fails;

    int   p_hi [4];
    int   n_hi [4];
    int   both_hi, compl_bad, uev_seen, cnt_max, dir_chg, dir_bad;

    pwm_tim_mc_if #(.WIDTH(16), .NUM_CH(4), .PSC_WIDTH(16), .DT_WIDTH(8)) bus ();

    pwm_tim_mc #(.WIDTH(16), .NUM_CH(4), .PSC_WIDTH(16), .DT_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic setup(input logic [15:0] psc, input logic [1:0] mode, input logic [15:0] arr,
                         input logic [63:0] pls, input logic pre, input logic [7:0] dt);
        bus.enable              = 1'b0;
        bus.prescaler           = psc;
        bus.counter_mode        = mode;
        bus.counter_period      = arr;
        bus.pulse               = pls;
        bus.auto_reload_preload = pre;
        bus.dead_time           = dt;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_uev(output int t, output logic [15:0] c);
        t = -1;
        c = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.update_evt === 1'b1) begin
                t = cyc;
                c = bus.cnt_o;
                break;
            end
        end
    endtask

    task automatic capture(input int n, input logic [15:0] arr);
        logic prev_dir;
        for (int ch = 0; ch < 4; ch++) begin p_hi[ch] = 0; n_hi[ch] = 0; end
        both_hi = 0; compl_bad = 0; uev_seen = 0; cnt_max = 0; dir_chg = 0; dir_bad = 0;
        prev_dir = bus.dir_o;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int ch = 0; ch < 4; ch++) begin
                p_hi[ch] += int'(bus.out_p[ch]);
                n_hi[ch] += int'(bus.out_n[ch]);
            end
            if ((bus.out_p & bus.out_n) != 4'b0) both_hi++;
            if (bus.out_n !== ~bus.out_p) compl_bad++;
            if (bus.update_evt) uev_seen++;
            if (int'(bus.cnt_o) > cnt_max) cnt_max = int'(bus.cnt_o);
            if (bus.dir_o != prev_dir) dir_chg++;
            if ((bus.cnt_o == arr && bus.dir_o !== 1'b1) || (bus.cnt_o == 16'd0 && bus.dir_o !== 1'b0)) dir_bad++;
            prev_dir = bus.dir_o;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk);
        tests++; if (bus.cnt_o !== 16'd0) begin fails++; $display("FAIL reset_cnt got %0d exp 0", bus.cnt_o); end
        tests++; if (bus.dir_o !== 1'b0) begin fails++; $display("FAIL reset_dir got %b exp 0", bus.dir_o); end
        tests++; if (bus.update_evt !== 1'b0) begin fails++; $display("FAIL reset_uev got %b exp 0", bus.update_evt); end
        tests++; if (bus.out_p !== 4'b0) begin fails++; $display("FAIL reset_out_p got %b exp 0000", bus.out_p); end
        tests++; if (bus.out_n !== 4'b0) begin fails++; $display("FAIL reset_out_n got %b exp 0000", bus.out_n); end
        rst = 1'b1;
    endtask

    task automatic test_up();
        int e0, e1, e2;
        logic [15:0] c0, c1, c2;
        do_reset();
        setup(16'd2, 2'b00, 16'd10, {16'd0, 16'd0, 16'd0, 16'd5}, 1'b0, 8'd0);
        bus.enable = 1'b1;
        wait_uev(e0, c0); wait_uev(e1, c1); wait_uev(e2, c2);
        tests++; if (e1 - e0 != 33) begin fails++; $display("FAIL up_period1 got %0d exp 33", e1 - e0); end
        tests++; if (e2 - e1 != 33) begin fails++; $display("FAIL up_period2 got %0d exp 33", e2 - e1); end
        tests++; if (c1 !== 16'd0) begin fails++; $display("FAIL up_reload_cnt got %0d exp 0", c1); end
        capture(33, 16'd10);
        tests++; if (p_hi[0] != 15) begin fails++; $display("FAIL up_high got %0d exp 15", p_hi[0]); end
        tests++; if (compl_bad != 0) begin fails++; $display("FAIL up_complement got %0d bad exp 0", compl_bad); end
    endtask

    task automatic test_center();
        int e0, e1, e2;
        logic [15:0] c0, c1, c2;
        do_reset();
        setup(16'd2, 2'b10, 16'd10, {16'd0, 16'd0, 16'd0, 16'd5}, 1'b0, 8'd0);
        bus.enable = 1'b1;
        wait_uev(e0, c0); wait_uev(e1, c1); wait_uev(e2, c2);
        tests++; if (e1 - e0 != 60) begin fails++; $display("FAIL ctr_period1 got %0d exp 60", e1 - e0); end
        tests++; if (e2 - e1 != 60) begin fails++; $display("FAIL ctr_period2 got %0d exp 60", e2 - e1); end
        capture(60, 16'd10);
        tests++; if (p_hi[0] != 27) begin fails++; $display("FAIL ctr_high got %0d exp 27", p_hi[0]); end
        tests++; if (cnt_max != 10) begin fails++; $display("FAIL ctr_peak got %0d exp 10", cnt_max); end
        tests++; if (dir_chg != 2) begin fails++; $display("FAIL ctr_dir_toggles got %0d exp 2", dir_chg); end
        tests++; if (dir_bad != 0) begin fails++; $display("FAIL ctr_dir_at_ends got %0d bad exp 0", dir_bad); end
    endtask

    task automatic test_down_preload();
        int e0, e1, e2, e3, e4, e5;
        logic [15:0] c0, c1, c2, c3, c4, c5;
        do_reset();
        setup(16'd0, 2'b01, 16'd10, {16'd0, 16'd0, 16'd0, 16'd5}, 1'b1, 8'd0);
        bus.enable = 1'b1;
        wait_uev(e0, c0); wait_uev(e1, c1); wait_uev(e2, c2);
        tests++; if (e2 - e1 != 11) begin fails++; $display("FAIL dn_period got %0d exp 11", e2 - e1); end
        tests++; if (bus.dir_o !== 1'b1) begin fails++; $display("FAIL dn_dir got %b exp 1", bus.dir_o); end
        repeat (4) @(negedge clk);
        bus.counter_period = 16'd15;
        wait_uev(e3, c3); wait_uev(e4, c4); wait_uev(e5, c5);
        tests++; if (e3 - e2 != 11) begin fails++; $display("FAIL dn_pre_end got %0d exp 11", e3 - e2); end
        tests++; if (c3 !== 16'd10) begin fails++; $display("FAIL dn_pre_reload1 got %0d exp 10", c3); end
        tests++; if (c4 !== 16'd15) begin fails++; $display("FAIL dn_pre_reload2 got %0d exp 15", c4); end
        tests++; if (e5 - e4 != 16) begin fails++; $display("FAIL dn_pre_newper got %0d exp 16", e5 - e4); end
        do_reset();
        setup(16'd0, 2'b01, 16'd10, {16'd0, 16'd0, 16'd0, 16'd5}, 1'b0, 8'd0);
        bus.enable = 1'b1;
        wait_uev(e0, c0); wait_uev(e1, c1); wait_uev(e2, c2);
        repeat (4) @(negedge clk);
        bus.counter_period = 16'd15;
        wait_uev(e3, c3); wait_uev(e4, c4);
        tests++; if (e3 - e2 != 11) begin fails++; $display("FAIL dn_dir_end got %0d exp 11", e3 - e2); end
        tests++; if (c3 !== 16'd15) begin fails++; $display("FAIL dn_dir_reload got %0d exp 15", c3); end
        tests++; if (e4 - e3 != 16) begin fails++; $display("FAIL dn_dir_newper got %0d exp 16", e4 - e3); end
    endtask

    task automatic test_channels();
        do_reset();
        setup(16'd0, 2'b00, 16'd10, {16'd10, 16'd3, 16'd11, 16'd0}, 1'b0, 8'd0);
        bus.enable = 1'b1;
        repeat (30) @(negedge clk);
        capture(22, 16'd10);
        tests++; if (p_hi[0] != 0) begin fails++; $display("FAIL ch0_ccr0 got %0d exp 0", p_hi[0]); end
        tests++; if (p_hi[1] != 22) begin fails++; $display("FAIL ch1_ccr_gt_arr got %0d exp 22", p_hi[1]); end
        tests++; if (p_hi[2] != 6) begin fails++; $display("FAIL ch2_ccr3 got %0d exp 6", p_hi[2]); end
        tests++; if (p_hi[3] != 20) begin fails++; $display("FAIL ch3_ccr_eq_arr got %0d exp 20", p_hi[3]); end
        tests++; if (compl_bad != 0) begin fails++; $display("FAIL ch_complement got %0d bad exp 0", compl_bad); end
    endtask

    task automatic test_one_pulse();
        int c_en, t;
        logic [15:0] c;
        do_reset();
        setup(16'd0, 2'b11, 16'd4, {16'd0, 16'd0, 16'd0, 16'd2}, 1'b0, 8'd0);
        bus.enable = 1'b1;
        c_en = cyc;
        wait_uev(t, c);
        tests++; if (t != c_en + 5) begin fails++; $display("FAIL opm_first got %0d exp %0d", t, c_en + 5); end
        capture(30, 16'd4);
        tests++; if (uev_seen != 0) begin fails++; $display("FAIL opm_extra_uev got %0d exp 0", uev_seen); end
        tests++; if (cnt_max != 0) begin fails++; $display("FAIL opm_hold got %0d exp 0", cnt_max); end
        bus.enable = 1'b0;
        repeat (2) @(negedge clk);
        bus.enable = 1'b1;
        c_en = cyc;
        wait_uev(t, c);
        tests++; if (t != c_en + 5) begin fails++; $display("FAIL opm_rearm got %0d exp %0d", t, c_en + 5); end
    endtask

    task automatic test_async_reset();
        do_reset();
        setup(16'd0, 2'b00, 16'd10, {16'd0, 16'd0, 16'd0, 16'd5}, 1'b0, 8'd0);
        bus.enable = 1'b1;
        repeat (7) @(negedge clk);
        tests++; if (bus.cnt_o !== 16'd7) begin fails++; $display("FAIL ar_precount got %0d exp 7", bus.cnt_o); end
        #2 rst = 1'b0;
        #1;
        tests++; if (bus.cnt_o !== 16'd0) begin fails++; $display("FAIL ar_cnt got %0d exp 0", bus.cnt_o); end
        tests++; if ({bus.out_p, bus.out_n} !== 8'b0) begin fails++; $display("FAIL ar_outs got %b exp 0", {bus.out_p, bus.out_n}); end
        bus.enable = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus.enable = 1'b1;
        @(negedge clk);
        tests++; if (bus.cnt_o !== 16'd1) begin fails++; $display("FAIL ar_restart1 got %0d exp 1", bus.cnt_o); end
        tests++; if (bus.out_p[0] !== 1'b1) begin fails++; $display("FAIL ar_out_p0 got %b exp 1", bus.out_p[0]); end
        @(negedge clk);
        tests++; if (bus.cnt_o !== 16'd2) begin fails++; $display("FAIL ar_restart2 got %0d exp 2", bus.cnt_o); end
    endtask

    task automatic test_dead_time();
`ifdef PWM_DEADTIME_EN
        localparam int EP0 = 4, EN0 = 6, EP1 = 0, EN1 = 12;
`else
        localparam int EP0 = 10, EN0 = 12, EP1 = 4, EN1 = 18;
`endif
        do_reset();
        setup(16'd0, 2'b00, 16'd10, {16'd0, 16'd0, 16'd2, 16'd5}, 1'b0, 8'd3);
        bus.enable = 1'b1;
        repeat (30) @(negedge clk);
        capture(22, 16'd10);
        tests++; if (p_hi[0] != EP0) begin fails++; $display("FAIL dt_p0 got %0d exp %0d", p_hi[0], EP0); end
        tests++; if (n_hi[0] != EN0) begin fails++; $display("FAIL dt_n0 got %0d exp %0d", n_hi[0], EN0); end
        tests++; if (p_hi[1] != EP1) begin fails++; $display("FAIL dt_p1_short got %0d exp %0d", p_hi[1], EP1); end
        tests++; if (n_hi[1] != EN1) begin fails++; $display("FAIL dt_n1 got %0d exp %0d", n_hi[1], EN1); end
        tests++; if (both_hi != 0) begin fails++; $display("FAIL dt_overlap got %0d exp 0", both_hi); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        cyc   = 0;
        rst   = 1'b1;
        bus.enable              = 1'b0;
        bus.prescaler           = '0;
        bus.counter_mode        = 2'b00;
        bus.counter_period      = '0;
        bus.pulse               = '0;
        bus.auto_reload_preload = 1'b0;
        bus.dead_time           = '0;
        @(negedge clk);
        test_reset();
        test_up();
        test_center();
        test_down_preload();
        test_channels();
        test_one_pulse();
        test_async_reset();
        test_dead_time();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
